arb8_way16: RTL
===============

ARB8_WAY16 -- requirements
Module: arb8_way16

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4, words a requester may move per grant when the burst limit is compiled in (legal range 1..255).
REQ-002 SHALL have port clk  input  1  sole clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port req  input  8  per-requester request; bit i asserts requester i has a word on din.
REQ-005 SHALL have port din  input  128  eight 16-bit words; requester i drives din[16*i+15:16*i].
REQ-006 SHALL have port ack  output  8  one-hot; bit i high for exactly the cycle requester i's word is captured.
REQ-007 SHALL have port gnt  output  8  one-hot registered grant; all-zero when idle.
REQ-008 SHALL have port sel  output  3  binary index of granted requester; drives the 8-way 16-bit word selector.
REQ-009 SHALL have port out  output  16  registered selected word.
REQ-010 SHALL have port out_valid  output  1  out holds a word not yet consumed.
REQ-011 SHALL have port out_ready  input  1  consumer accepts out this cycle when out_valid high.

Function
REQ-012 SHALL implement a two-state FSM: IDLE, BUSY.
REQ-013 In IDLE with any req bit high, SHALL pick the first set bit searching (last+1) mod 8 upward with wrap, load gnt/sel, enter BUSY next cycle (req-to-gnt latency 1 cycle).
REQ-014 In IDLE with req all-zero, SHALL stay IDLE, gnt=0, sel unchanged.
REQ-015 Load condition ld = BUSY & req[sel] & (!out_valid | out_ready).
REQ-016 On ld, SHALL assert ack[sel] combinationally that cycle and next cycle present out=din word sel, out_valid=1.
REQ-017 Without ld and with out_valid & out_ready, SHALL clear out_valid next cycle.
REQ-018 While out_valid & !out_ready, out SHALL remain stable and no ack SHALL assert.
REQ-019 In BUSY with req[sel]=0, SHALL return to IDLE next cycle, set last=sel, clear gnt; pending out word is unaffected and still drains by out_ready.
REQ-020 Release costs one idle bubble cycle; back-to-back requesters see ≥1 cycle between final ack and next grant.
REQ-021 Requests from non-granted requesters SHALL NOT preempt the current grant.
REQ-022 Throughput SHALL be one word per cycle when req[sel] and out_ready stay high.
REQ-023 sel SHALL change only on the IDLE-to-BUSY transition.

Reset
REQ-024 On rst_n low, SHALL asynchronously force: state IDLE, gnt=0, sel=0, last=7 (requester 0 highest priority first), out=16'h0000, out_valid=0, burst count=0, ack=0.
REQ-025 Reset mid-BUSY SHALL discard the in-flight out word; no ack SHALL assert while rst_n low.
REQ-026 After rst_n rises, first grant SHALL occur no earlier than the first rising edge with rst_n high.

Configuration
REQ-027 Macro ARB_BURST_LIMIT_EN defined: 8-bit burst counter SHALL count ld events per grant; on the ld that makes count equal MAX_BURST, SHALL return to IDLE next cycle with last=sel, count=0, even if req[sel] still high.
REQ-028 Macro ARB_BURST_LIMIT_EN undefined: no counter SHALL exist; grant held until req[sel] drops; MAX_BURST ignored.

Verification
REQ-029 Reset: rst_n low mid-transfer -> gnt=0, out=0, out_valid=0, ack=0 immediately; after release req=8'h01 -> gnt=8'h01, sel=0 one cycle later.
REQ-030 Round-robin: req=8'hFF held, out_ready=1, each requester drops req after 2 acks -> grant order 0,1,2,...,7,0, each 2 words, one bubble between grants.
REQ-031 Wrap: last=6, req=8'h41 -> gnt=8'h40? no: search from 7 wraps to 0 -> gnt=8'h01, sel=0.
REQ-032 Backpressure: grant 3, din word3=16'hBEEF, out_ready=0 for 4 cycles -> out=16'hBEEF, out_valid=1 stable, ack=0 for those cycles; out_ready=1 -> ack[3] resumes same cycle.
REQ-033 Burst limit (macro defined, MAX_BURST=4): req=8'h05 held, out_ready=1 -> requester 0 gets exactly 4 acks, then requester 2 gets 4, alternating; macro undefined -> requester 0 holds indefinitely.
REQ-034 Preemption: grant on 5 streaming, req[1] rises -> gnt stays 8'h20 until req[5] falls, then gnt=8'h02.

Source files
------------

// File: rtl/arb8_way16.sv
// Eight-requester round-robin arbiter feeding a registered 16-bit word stage with valid/ready.
// Define ARB_BURST_LIMIT_EN to cap each grant at MAX_BURST captured words.
module arb8_way16 #(
    parameter int unsigned MAX_BURST = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [7:0]   req,
    input  logic [127:0] din,
    output logic [7:0]   ack,
    output logic [7:0]   gnt,
    output logic [2:0]   sel,
    output logic [15:0]  out,
    output logic         out_valid,
    input  logic         out_ready
);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    if (MAX_BURST < 1 || MAX_BURST > 255) begin : g_bad_max_burst
        $error("arb8_way16: MAX_BURST must be within 1..255");
    end

    logic [0:0] state;
    logic [2:0] last;
    logic [2:0] pick;
    logic       found;
    logic       ld;
    logic       burst_done;
    logic       release_now;

    // Search starts just after the last served requester; i=8 wraps back onto last itself.
    always_comb begin
        pick  = last;
        found = 1'b0;
        for (int unsigned i = 1; i <= 8; i++) begin
            if (!found && req[last + 3'(i)]) begin
                found = 1'b1;
                pick  = last + 3'(i);
            end
        end
    end

    assign ld          = (state == BUSY) && req[sel] && (!out_valid || out_ready);
    assign ack         = ld ? (8'b1 << sel) : '0;
    assign release_now = (state == BUSY) && (!req[sel] || burst_done);

`ifdef ARB_BURST_LIMIT_EN
    logic [7:0] burst_cnt;

    assign burst_done = ld && ((burst_cnt + 8'd1) == 8'(MAX_BURST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            burst_cnt <= '0;
        end else if (release_now) begin
            burst_cnt <= '0;
        end else if (ld) begin
            burst_cnt <= burst_cnt + 8'd1;
        end
    end
`else
    assign burst_done = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= '0;
            sel   <= '0;
            last  <= 3'd7;
        end else if (state == IDLE) begin
            if (found) begin
                state <= BUSY;
                gnt   <= 8'b1 << pick;
                sel   <= pick;
            end else begin
                gnt   <= '0;
            end
        end else if (release_now) begin
            state <= IDLE;
            last  <= sel;
            gnt   <= '0;
        end
    end

    // Output register drains independently of the grant FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out       <= '0;
            out_valid <= 1'b0;
        end else if (ld) begin
            out       <= din[{sel, 4'b0000} +: 16];
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
